// File: rtl/popcount_plane_accumulator_if.sv
// Beat-in / result-out handshake bundle for popcount_plane_accumulator.
interface popcount_plane_accumulator_if #(
    parameter int COLS    = 8,
    parameter int SHIFT_W = 3,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [COLS-1:0]    in_sum;
    logic [COLS-1:0]    in_carry;
    logic [COLS-1:0]    in_cout;
    logic [SHIFT_W-1:0] in_shift;
    logic               in_neg;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_data;
    logic               out_overflow;
    logic [CNT_W-1:0]   out_beats;

    modport slave (
        input  in_valid, in_sum, in_carry, in_cout, in_shift, in_neg, in_last, out_ready,
        output in_ready, out_valid, out_data, out_overflow, out_beats
    );

    modport master (
        output in_valid, in_sum, in_carry, in_cout, in_shift, in_neg, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_overflow, out_beats
    );
endinterface

// File: rtl/popcount_plane_accumulator.sv
// Reduces each beat of 7:3 counter outputs to a shifted, optionally negated term and
// accumulates it per frame. Define NPU_ACC_SAT_EN to clamp on overflow instead of wrapping.
module popcount_plane_accumulator #(
    parameter int COLS    = 8,
    parameter int SHIFT_W = 3,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    popcount_plane_accumulator_if.slave bus
);
    localparam int VAL_W  = $clog2(7 * COLS + 1);
    localparam int MAG_W  = VAL_W + (1 << SHIFT_W) - 1;
    // Term is at least ACC_W+1 bits, wider if a max shift would not fit, so the sum stays exact.
    localparam int TERM_W = (ACC_W + 1 > MAG_W + 1) ? (ACC_W + 1) : (MAG_W + 1);
    localparam int SUM_W  = TERM_W + 1;
    localparam int TOP_W  = SUM_W - ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_data_q;
    logic               out_ovf_q;
    logic [CNT_W-1:0]   out_beats_q;

    logic               s1_valid_q;
    logic               s1_last_q;
    logic [TERM_W-1:0]  s1_term_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;

    logic               accept_s;
    logic               load_s;
    logic [VAL_W-1:0]   beat_val_s;
    logic [TERM_W-1:0]  mag_s;
    logic [TERM_W-1:0]  term_s;
    logic [SUM_W-1:0]   sum_s;
    logic               step_ovf_s;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_d;

    // True when the exact sum does not fit the signed ACC_W range (upper bits not a sign run).
    function automatic logic range_exceeded(input logic [SUM_W-1:0] v);
        logic [TOP_W-1:0] top;
        top = v[SUM_W-1:ACC_W-1];
        return !((&top) || (~|top));
    endfunction

    assign accept_s = bus.in_valid & in_ready_q;
    assign load_s   = s1_valid_q & s1_last_q;

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_overflow = out_ovf_q;
    assign bus.out_beats    = out_beats_q;

    // Beat reduction: {cout,carry,sum} of a column is already its 3-bit weighted value.
    always_comb begin
        beat_val_s = {VAL_W{1'b0}};
        for (int i = 0; i < COLS; i++) begin
            beat_val_s = beat_val_s + VAL_W'({bus.in_cout[i], bus.in_carry[i], bus.in_sum[i]});
        end
        mag_s = TERM_W'(beat_val_s) << bus.in_shift;
        if (bus.in_neg) begin
            term_s = ~mag_s + TERM_W'(1);
        end else begin
            term_s = mag_s;
        end
    end

    // Stage-2 add with exact-range overflow detection and wrap/clamp of the stored value.
    always_comb begin
        sum_s      = {{(SUM_W - ACC_W){acc_q[ACC_W-1]}}, acc_q}
                   + {{(SUM_W - TERM_W){s1_term_q[TERM_W-1]}}, s1_term_q};
        step_ovf_s = range_exceeded(sum_s);
`ifdef NPU_ACC_SAT_EN
        if (step_ovf_s) begin
            acc_d = sum_s[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_d = sum_s[ACC_W-1:0];
        end
`else
        acc_d = sum_s[ACC_W-1:0];
`endif
        ovf_d = ovf_q | step_ovf_s;
    end

    // Stage 1: capture term and last flag, count beats with saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_term_q  <= {TERM_W{1'b0}};
            beat_cnt_q <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q <= accept_s;
            s1_last_q  <= accept_s & bus.in_last;
            if (accept_s) begin
                s1_term_q <= term_s;
            end else begin
                s1_term_q <= s1_term_q;
            end
            if (load_s) begin
                beat_cnt_q <= {CNT_W{1'b0}};
            end else if (accept_s && (beat_cnt_q != {CNT_W{1'b1}})) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end else begin
                beat_cnt_q <= beat_cnt_q;
            end
        end
    end

    // Stage 2 accumulator plus frame FSM; result registers load on the last term's add.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= {ACC_W{1'b0}};
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_W{1'b0}};
            out_ovf_q   <= 1'b0;
            out_beats_q <= {CNT_W{1'b0}};
        end else begin
            if (load_s) begin
                acc_q <= {ACC_W{1'b0}};
                ovf_q <= 1'b0;
            end else if (s1_valid_q) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
            end else begin
                acc_q <= acc_q;
                ovf_q <= ovf_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept_s && bus.in_last) begin
                        state_q    <= S_DRAIN;
                        in_ready_q <= 1'b0;
                    end else if (accept_s) begin
                        state_q    <= S_ACCUM;
                        in_ready_q <= 1'b1;
                    end else begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (accept_s && bus.in_last) begin
                        state_q    <= S_DRAIN;
                        in_ready_q <= 1'b0;
                    end else begin
                        state_q    <= S_ACCUM;
                        in_ready_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    in_ready_q <= 1'b0;
                    if (load_s) begin
                        state_q     <= S_OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_d;
                        out_ovf_q   <= ovf_d;
                        out_beats_q <= beat_cnt_q;
                    end else begin
                        state_q     <= S_DRAIN;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        state_q     <= S_OUT;
                        in_ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_plane_accumulator.sv
// Randomized self-checking bench: a 24-bit and an 8-bit accumulator share one stimulus stream.
module tb_popcount_plane_accumulator;
    localparam int COLS    = 8;
    localparam int SHIFT_W = 3;
    localparam int CNT_W   = 8;
    localparam int ACC_A   = 24;
    localparam int ACC_B   = 8;
`ifdef NPU_ACC_SAT_EN
    localparam logic [63:0] T4_B = 64'h7F;
    localparam logic [63:0] T6_B = 64'h7F;
`else
    localparam logic [63:0] T4_B = 64'hE0;
    localparam logic [63:0] T6_B = 64'h00;
`endif

    logic        clk;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdy_mode = 0;

    longint      frame_terms[$];
    bit          busy = 1'b0;
    bit          pend = 1'b0;
    int          pend_from = 0;
    logic [63:0] exp_data_a, exp_data_b;
    bit          exp_ovf_a, exp_ovf_b;
    int          exp_beats;

    popcount_plane_accumulator_if #(.COLS(COLS), .SHIFT_W(SHIFT_W), .ACC_W(ACC_A), .CNT_W(CNT_W)) if_a ();
    popcount_plane_accumulator_if #(.COLS(COLS), .SHIFT_W(SHIFT_W), .ACC_W(ACC_B), .CNT_W(CNT_W)) if_b ();

    assign if_b.in_valid  = if_a.in_valid;
    assign if_b.in_sum    = if_a.in_sum;
    assign if_b.in_carry  = if_a.in_carry;
    assign if_b.in_cout   = if_a.in_cout;
    assign if_b.in_shift  = if_a.in_shift;
    assign if_b.in_neg    = if_a.in_neg;
    assign if_b.in_last   = if_a.in_last;
    assign if_b.out_ready = if_a.out_ready;

    popcount_plane_accumulator #(.COLS(COLS), .SHIFT_W(SHIFT_W), .ACC_W(ACC_A), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a));
    popcount_plane_accumulator #(.COLS(COLS), .SHIFT_W(SHIFT_W), .ACC_W(ACC_B), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Value of one beat: weighted popcount, shifted, optionally negated.
    function automatic longint beat_term(input logic [7:0] co, input logic [7:0] ca,
                                         input logic [7:0] su, input logic [2:0] sh, input logic ng);
        longint v;
        v = longint'(4 * $countones(co) + 2 * $countones(ca) + $countones(su));
        v = v << sh;
        return ng ? -v : v;
    endfunction

    // Frame result for a w-bit signed accumulator over the collected terms.
    function automatic void model_frame(input int w, output logic [63:0] res, output bit ovf);
        longint acc, hi, lo, m;
        m   = longint'(1) << w;
        hi  = (m >> 1) - 1;
        lo  = -(m >> 1);
        acc = 0;
        ovf = 1'b0;
        foreach (frame_terms[k]) begin
            acc = acc + frame_terms[k];
            if (acc > hi || acc < lo) begin
                ovf = 1'b1;
`ifdef NPU_ACC_SAT_EN
                acc = (acc > hi) ? hi : lo;
`else
                acc = ((acc - lo) % m + m) % m + lo;
`endif
            end
        end
        res = 64'(acc & (m - 1));
    endfunction

    // Per-cycle compare of both DUTs against the frame-level model.
    always @(negedge clk) begin
        bit was_busy;
        bit exp_ov;
        cyc++;
        if (reset) begin
            frame_terms.delete();
            busy = 1'b0;
            pend = 1'b0;
        end else begin
            was_busy = busy;
            exp_ov   = pend && (cyc >= pend_from);
            chk("in_ready_a", 64'(if_a.in_ready), 64'(!was_busy));
            chk("in_ready_b", 64'(if_b.in_ready), 64'(!was_busy));
            chk("out_valid_a", 64'(if_a.out_valid), 64'(exp_ov));
            chk("out_valid_b", 64'(if_b.out_valid), 64'(exp_ov));
            if (exp_ov) begin
                chk("out_data_a", 64'(if_a.out_data), exp_data_a);
                chk("out_data_b", 64'(if_b.out_data), exp_data_b);
                chk("out_overflow_a", 64'(if_a.out_overflow), 64'(exp_ovf_a));
                chk("out_overflow_b", 64'(if_b.out_overflow), 64'(exp_ovf_b));
                chk("out_beats_a", 64'(if_a.out_beats), 64'(exp_beats));
                chk("out_beats_b", 64'(if_b.out_beats), 64'(exp_beats));
                if (if_a.out_ready === 1'b1) begin
                    pend = 1'b0;
                    busy = 1'b0;
                end
            end
            if (if_a.in_valid === 1'b1 && !was_busy) begin
                frame_terms.push_back(beat_term(if_a.in_cout, if_a.in_carry, if_a.in_sum,
                                                if_a.in_shift, if_a.in_neg));
                if (if_a.in_last === 1'b1) begin
                    model_frame(ACC_A, exp_data_a, exp_ovf_a);
                    model_frame(ACC_B, exp_data_b, exp_ovf_b);
                    exp_beats = (frame_terms.size() > 255) ? 255 : frame_terms.size();
                    pend      = 1'b1;
                    pend_from = cyc + 2;
                    busy      = 1'b1;
                    frame_terms.delete();
                end
            end
        end
    end

    initial begin
        if_a.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       if_a.out_ready = 1'b1;
                1:       if_a.out_ready = 1'($urandom_range(0, 1));
                default: if_a.out_ready = 1'b0;
            endcase
        end
    end

    task automatic send_beat(input logic [7:0] co, input logic [7:0] ca, input logic [7:0] su,
                             input logic [2:0] sh, input logic ng, input logic lst);
        int n;
        if_a.in_valid = 1'b1;
        if_a.in_cout  = co;
        if_a.in_carry = ca;
        if_a.in_sum   = su;
        if_a.in_shift = sh;
        if_a.in_neg   = ng;
        if_a.in_last  = lst;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (if_a.in_ready !== 1'b1 && n < 500);
        chk("beat_accept_wait", 64'(if_a.in_ready), 64'd1);
        @(posedge clk);
        #1;
        if_a.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string nm, input logic [63:0] da, input logic [63:0] db,
                               input bit oa, input bit ob, input int beats);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (if_a.out_valid !== 1'b1 && n < 400);
        chk({nm, "_latency"}, 64'(n), 64'd2);
        chk({nm, "_data_a"}, 64'(if_a.out_data), da);
        chk({nm, "_data_b"}, 64'(if_b.out_data), db);
        chk({nm, "_ovf_a"}, 64'(if_a.out_overflow), 64'(oa));
        chk({nm, "_ovf_b"}, 64'(if_b.out_overflow), 64'(ob));
        chk({nm, "_beats"}, 64'(if_a.out_beats), 64'(beats));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        if_a.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int len;
        int n;
        reset = 1'b1;
        if_a.in_valid = 1'b0;
        if_a.in_cout  = 8'h00;
        if_a.in_carry = 8'h00;
        if_a.in_sum   = 8'h00;
        if_a.in_shift = 3'd0;
        if_a.in_neg   = 1'b0;
        if_a.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(if_a.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst_out_data", 64'(if_a.out_data), 64'd0);
        chk("rst_out_overflow", 64'(if_a.out_overflow), 64'd0);
        chk("rst_out_beats", 64'(if_a.out_beats), 64'd0);
        @(posedge clk);
        #1;

        send_beat(8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1);
        wait_result("single56", 64'd56, 64'h38, 1'b0, 1'b0, 1);

        send_beat(8'h01, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0);
        send_beat(8'h00, 8'h00, 8'h01, 3'd3, 1'b1, 1'b1);
        wait_result("minus1", 64'hFFFFFF, 64'hFF, 1'b0, 1'b0, 2);

        rdy_mode = 2;
        send_beat(8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1);
        wait_result("stall", 64'd56, 64'd56, 1'b0, 1'b0, 1);
        fork
            send_beat(8'h00, 8'h01, 8'h01, 3'd2, 1'b0, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(if_a.in_ready), 64'd0);
                    chk("stall_out_valid", 64'(if_a.out_valid), 64'd1);
                    chk("stall_out_data", 64'(if_a.out_data), 64'd56);
                    chk("stall_out_beats", 64'(if_a.out_beats), 64'd1);
                end
                rdy_mode = 0;
            end
        join
        wait_result("after_stall", 64'd12, 64'd12, 1'b0, 1'b0, 1);

        send_beat(8'hFF, 8'hFF, 8'hFF, 3'd1, 1'b0, 1'b0);
        send_beat(8'hFF, 8'hFF, 8'hFF, 3'd1, 1'b0, 1'b1);
        wait_result("ovf224", 64'hE0, T4_B, 1'b0, 1'b1, 2);

        send_beat(8'h0F, 8'h00, 8'h33, 3'd2, 1'b0, 1'b0);
        send_beat(8'h00, 8'hA0, 8'h00, 3'd5, 1'b1, 1'b0);
        send_beat(8'hFF, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0);
        pulse_reset();
        send_beat(8'h00, 8'h01, 8'h01, 3'd0, 1'b0, 1'b1);
        wait_result("post_reset", 64'd3, 64'd3, 1'b0, 1'b0, 1);

        send_beat(8'hFF, 8'hFF, 8'hFF, 3'd7, 1'b0, 1'b1);
        wait_result("shift7", 64'd7168, T6_B, 1'b0, 1'b1, 1);
        for (int b = 0; b < 301; b++) begin
            send_beat(8'h00, 8'h00, 8'h00, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), b == 300);
        end
        wait_result("zeros_sat", 64'd0, 64'd0, 1'b0, 1'b0, 255);

        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            len = (f == 20) ? 6 : $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                send_beat(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), b == len - 1);
                if (f == 20 && b == 1) pulse_reset();
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        n = 0;
        while ((pend || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("final_drain", 64'(pend || busy), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
